// File: rtl/id_stage_pkg.sv
// Shared definitions for the decode stage: bus widths, opcodes, decode-bus
// field layout (also consumed by EX) and branch offset helpers.
package id_stage_pkg;

    localparam int unsigned FS_BUS_W = 65;
    localparam int unsigned DS_BUS_W = 135;
    localparam int unsigned BR_BUS_W = 33;

    // Major opcodes, inst[31:26]
    localparam logic [5:0] OP_JIRL = 6'h13;
    localparam logic [5:0] OP_B    = 6'h14;
    localparam logic [5:0] OP_BL   = 6'h15;
    localparam logic [5:0] OP_BEQ  = 6'h16;
    localparam logic [5:0] OP_BNE  = 6'h17;
    localparam logic [5:0] OP_BLT  = 6'h18;
    localparam logic [5:0] OP_BGE  = 6'h19;
    localparam logic [5:0] OP_BLTU = 6'h1a;
    localparam logic [5:0] OP_BGEU = 6'h1b;

    // Store group, inst[31:24]
    localparam logic [7:0] OP8_STORE = 8'h29;

    // Immediate-only forms without an rj source, inst[31:25]
    localparam logic [6:0] OP7_LU12I     = 7'h0a;
    localparam logic [6:0] OP7_PCADDU12I = 7'h0e;

    // ds_to_es_bus field layout
    localparam int unsigned DS_ADEF_BIT  = 134;
    localparam int unsigned DS_GR_WE_BIT = 133;
    localparam int unsigned DS_DEST_LSB  = 128;
    localparam int unsigned DS_RKD_LSB   = 96;
    localparam int unsigned DS_RJ_LSB    = 64;
    localparam int unsigned DS_INST_LSB  = 32;
    localparam int unsigned DS_PC_LSB    = 0;

    // Fetch bus as seen by ID, MSB first
    typedef struct packed {
        logic        adef;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_bus_t;

    typedef enum logic [2:0] {
        BrNone,
        BrEq,
        BrNe,
        BrLt,
        BrGe,
        BrLtu,
        BrGeu
    } br_cond_e;

    // Word offsets are scaled by 4 and sign-extended to 32 bits
    function automatic logic [31:0] sext_offs16(input logic [15:0] offs);
        return {{14{offs[15]}}, offs, 2'b00};
    endfunction

    function automatic logic [31:0] sext_offs26(input logic [25:0] offs);
        return {{4{offs[25]}}, offs, 2'b00};
    endfunction

endpackage

// File: rtl/id_branch_unit.sv
// Branch resolution for ID: condition compare and target adder, purely
// combinational.
module id_branch_unit
    import id_stage_pkg::*;
(
    input  br_cond_e    cond,
    input  logic        is_jirl,
    input  logic        is_b26,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [31:0] rj_value,
    input  logic [31:0] rkd_value,
    output logic        cond_true,
    output logic [31:0] target
);

    logic [15:0] offs16;
    logic [25:0] offs26;

    assign offs16 = inst[25:10];
    assign offs26 = {inst[9:0], inst[25:10]};

    // Evaluate the conditional-branch predicate
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            BrEq:    cond_true = (rj_value == rkd_value);
            BrNe:    cond_true = (rj_value != rkd_value);
            BrLt:    cond_true = ($signed(rj_value) <  $signed(rkd_value));
            BrGe:    cond_true = ($signed(rj_value) >= $signed(rkd_value));
            BrLtu:   cond_true = (rj_value <  rkd_value);
            BrGeu:   cond_true = (rj_value >= rkd_value);
            default: cond_true = 1'b0;
        endcase
    end

    // Select base and offset for the branch target; adds wrap at 32 bits
    always_comb begin
        target = pc + sext_offs16(offs16);
        if (is_jirl) begin
            target = rj_value + sext_offs16(offs16);
        end else if (is_b26) begin
            target = pc + sext_offs26(offs26);
        end
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: latches the fetch bus, reads the register file,
// stalls on RAW hazards (no forwarding) and resolves branches back to fetch.
module id_stage
    import id_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                fs_to_ds_valid,
    input  logic [FS_BUS_W-1:0] fs_to_ds_bus,
    output logic                ds_allowin,
    output logic [BR_BUS_W-1:0] br_collect,
    input  logic                es_allowin,
    output logic                ds_to_es_valid,
    output logic [DS_BUS_W-1:0] ds_to_es_bus,
    output logic [4:0]          rf_raddr1,
    input  logic [31:0]         rf_rdata1,
    output logic [4:0]          rf_raddr2,
    input  logic [31:0]         rf_rdata2,
    input  logic [5:0]          es_dest_bus,
    input  logic [5:0]          ms_dest_bus,
    input  logic [5:0]          ws_dest_bus,
    input  logic                ws_flush
);

    fs_bus_t     fs_bus_q;
    logic        ds_valid_q;

    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_adef;
    logic [5:0]  opcode;

    logic        is_jirl;
    logic        is_b;
    logic        is_bl;
    logic        is_cond;
    logic        is_store;
    logic        is_3r;
    br_cond_e    br_cond;

    logic        src2_is_rd;
    logic        rj_used;
    logic        src2_used;
    logic [4:0]  dest;
    logic        gr_we;

    logic        hazard;
    logic        ds_ready_go;
    logic        cond_true;
    logic [31:0] br_target;
    logic        br_taken;

    assign inst      = fs_bus_q.inst;
    assign pc        = fs_bus_q.pc;
    assign inst_adef = fs_bus_q.adef;
    assign opcode    = inst[31:26];

    // Opcode decode and branch condition selection
    always_comb begin
        is_jirl  = (opcode == OP_JIRL);
        is_b     = (opcode == OP_B);
        is_bl    = (opcode == OP_BL);
        is_cond  = (opcode >= OP_BEQ) && (opcode <= OP_BGEU);
        is_store = (inst[31:24] == OP8_STORE);
        is_3r    = (inst[31:22] == 10'b0) && (inst[21:20] != 2'b00);
        br_cond  = BrNone;
        case (opcode)
            OP_BEQ:  br_cond = BrEq;
            OP_BNE:  br_cond = BrNe;
            OP_BLT:  br_cond = BrLt;
            OP_BGE:  br_cond = BrGe;
            OP_BLTU: br_cond = BrLtu;
            OP_BGEU: br_cond = BrGeu;
            default: br_cond = BrNone;
        endcase
    end

    // Register sources, destination and write enable
    always_comb begin
        src2_is_rd = is_cond | is_store;
        rj_used    = ~(is_b | is_bl | (inst[31:25] == OP7_LU12I)
                       | (inst[31:25] == OP7_PCADDU12I));
        src2_used  = is_cond | is_store | is_3r;
        dest       = is_bl ? 5'd1 : inst[4:0];
        gr_we      = ~(is_b | is_cond | is_store | inst_adef) && (dest != 5'd0);
        rf_raddr1  = inst[9:5];
        rf_raddr2  = src2_is_rd ? inst[4:0] : inst[14:10];
    end

    // RAW hazard: any valid downstream writer of a used, non-zero source
    always_comb begin
        hazard = 1'b0;
        if (rj_used && rf_raddr1 != 5'd0) begin
            hazard = hazard
                   | (es_dest_bus[5] && es_dest_bus[4:0] == rf_raddr1)
                   | (ms_dest_bus[5] && ms_dest_bus[4:0] == rf_raddr1)
                   | (ws_dest_bus[5] && ws_dest_bus[4:0] == rf_raddr1);
        end
        if (src2_used && rf_raddr2 != 5'd0) begin
            hazard = hazard
                   | (es_dest_bus[5] && es_dest_bus[4:0] == rf_raddr2)
                   | (ms_dest_bus[5] && ms_dest_bus[4:0] == rf_raddr2)
                   | (ws_dest_bus[5] && ws_dest_bus[4:0] == rf_raddr2);
        end
    end

    id_branch_unit u_branch (
        .cond      (br_cond),
        .is_jirl   (is_jirl),
        .is_b26    (is_b | is_bl),
        .pc        (pc),
        .inst      (inst),
        .rj_value  (rf_rdata1),
        .rkd_value (rf_rdata2),
        .cond_true (cond_true),
        .target    (br_target)
    );

    // Handshake and branch redirect; a faulting fetch never redirects and
    // never waits on operands since it only carries the exception to WB
    always_comb begin
        ds_ready_go    = ~hazard | inst_adef;
        ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin);
        ds_to_es_valid = ds_valid_q & ds_ready_go & ~ws_flush;
        // Only redirect when the branch actually moves to EX, otherwise
        // fetch would discard the target while ID is back-pressured
        br_taken       = ds_valid_q & ds_ready_go & es_allowin & ~ws_flush & ~inst_adef
                       & (is_b | is_bl | is_jirl | cond_true);
        br_collect     = {br_taken, br_target};
    end

    // Pack the decode bus; operands come straight from the register file
    always_comb begin
        ds_to_es_bus                                = '0;
        ds_to_es_bus[DS_ADEF_BIT]                   = inst_adef;
        ds_to_es_bus[DS_GR_WE_BIT]                  = gr_we;
        ds_to_es_bus[DS_DEST_LSB +: 5]              = dest;
        ds_to_es_bus[DS_RKD_LSB +: 32]              = rf_rdata2;
        ds_to_es_bus[DS_RJ_LSB +: 32]               = rf_rdata1;
        ds_to_es_bus[DS_INST_LSB +: 32]             = inst;
        ds_to_es_bus[DS_PC_LSB +: 32]               = pc;
    end

    // Stage valid and fetch-bus latch; the wrong-path successor of a taken
    // branch is dropped on the same edge the branch leaves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ds_valid_q <= 1'b0;
            fs_bus_q   <= '0;
        end else if (ds_allowin) begin
            ds_valid_q <= fs_to_ds_valid & ~br_taken & ~ws_flush;
            fs_bus_q   <= fs_to_ds_bus;
        end else if (ws_flush) begin
            ds_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a table of single-instruction vectors plus
// hand-written multi-cycle sequences for stall, back-pressure, flush and reset.
module tb_id_stage;
    import id_stage_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                fs_to_ds_valid;
    logic [FS_BUS_W-1:0] fs_to_ds_bus;
    logic                ds_allowin;
    logic [BR_BUS_W-1:0] br_collect;
    logic                es_allowin;
    logic                ds_to_es_valid;
    logic [DS_BUS_W-1:0] ds_to_es_bus;
    logic [4:0]          rf_raddr1;
    logic [31:0]         rf_rdata1;
    logic [4:0]          rf_raddr2;
    logic [31:0]         rf_rdata2;
    logic [5:0]          es_dest_bus;
    logic [5:0]          ms_dest_bus;
    logic [5:0]          ws_dest_bus;
    logic                ws_flush;

    id_stage dut (
        .clk            (clk),
        .reset          (reset),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .ds_allowin     (ds_allowin),
        .br_collect     (br_collect),
        .es_allowin     (es_allowin),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .rf_raddr1      (rf_raddr1),
        .rf_rdata1      (rf_rdata1),
        .rf_raddr2      (rf_raddr2),
        .rf_rdata2      (rf_rdata2),
        .es_dest_bus    (es_dest_bus),
        .ms_dest_bus    (ms_dest_bus),
        .ws_dest_bus    (ws_dest_bus),
        .ws_flush       (ws_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adef;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [5:0]  es_d;
        logic [5:0]  ms_d;
        logic [5:0]  ws_d;
        logic        es_allow;
        logic        flush;
        logic        e_valid;
        logic        e_allowin;
        logic        e_taken;
        logic [31:0] e_target;
        logic        e_gr_we;
        logic [4:0]  e_dest;
        logic [4:0]  e_raddr1;
        logic [4:0]  e_raddr2;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        fs_to_ds_valid = 1'b0;
        es_dest_bus    = 6'h00;
        ms_dest_bus    = 6'h00;
        ws_dest_bus    = 6'h00;
        ws_flush       = 1'b0;
        es_allowin     = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one edge so ID latches it
    task automatic load(input logic [31:0] inst, input logic [31:0] pc, input logic adef);
        fs_to_ds_bus   = {adef, inst, pc};
        fs_to_ds_valid = 1'b1;
        step();
        fs_to_ds_valid = 1'b0;
    endtask

    initial begin
        //              inst          pc            adef  rd1           rd2           es     ms     ws     ea    fl    val   alw   tkn   target        gw    dest   ra1    ra2
        vecs[0]  = '{32'h00100C41, 32'h1c000000, 1'b0, 32'd5,        32'd7,        6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 5'd1,  5'd2,  5'd3};
        vecs[1]  = '{32'h58001085, 32'h1c000010, 1'b0, 32'd9,        32'd9,        6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1c000020, 1'b0, 5'd5,  5'd4,  5'd5};
        vecs[2]  = '{32'h58001085, 32'h1c000010, 1'b0, 32'd9,        32'd8,        6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 5'd5,  5'd4,  5'd5};
        vecs[3]  = '{32'h00100C41, 32'h1c000000, 1'b0, 32'd5,        32'd7,        6'h22, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 5'd1,  5'd2,  5'd3};
        vecs[4]  = '{32'h00100C41, 32'h1c000000, 1'b0, 32'd5,        32'd7,        6'h00, 6'h00, 6'h23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 5'd1,  5'd2,  5'd3};
        vecs[5]  = '{32'h00100C41, 32'h1c000000, 1'b0, 32'd5,        32'd7,        6'h00, 6'h02, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 5'd1,  5'd2,  5'd3};
        vecs[6]  = '{32'h58001085, 32'h1c000010, 1'b0, 32'd9,        32'd9,        6'h25, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 5'd5,  5'd4,  5'd5};
        vecs[7]  = '{32'h4C0020C1, 32'h1c000030, 1'b0, 32'h1c001000, 32'd0,        6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1c001020, 1'b1, 5'd1,  5'd6,  5'd8};
        vecs[8]  = '{32'h4C0020C1, 32'h1c000030, 1'b0, 32'h1c001000, 32'd0,        6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 5'd1,  5'd6,  5'd8};
        vecs[9]  = '{32'h58001085, 32'h1c000002, 1'b1, 32'd9,        32'd9,        6'h24, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 5'd5,  5'd4,  5'd5};
        vecs[10] = '{32'h58001085, 32'h1c000010, 1'b0, 32'd9,        32'd9,        6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 5'd5,  5'd4,  5'd5};
        vecs[11] = '{32'h54000800, 32'h1c000100, 1'b0, 32'd0,        32'd0,        6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1c000108, 1'b1, 5'd1,  5'd0,  5'd2};
        vecs[12] = '{32'h53FFFFFF, 32'h1c000100, 1'b0, 32'd0,        32'd0,        6'h3f, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1c0000fc, 1'b0, 5'd31, 5'd31, 5'd31};
        vecs[13] = '{32'h60001085, 32'h1c000200, 1'b0, 32'hffffffff, 32'd1,        6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1c000210, 1'b0, 5'd5,  5'd4,  5'd5};
        vecs[14] = '{32'h68001085, 32'h1c000200, 1'b0, 32'hffffffff, 32'd1,        6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 5'd5,  5'd4,  5'd5};
        vecs[15] = '{32'h6C001085, 32'h1c000200, 1'b0, 32'hffffffff, 32'd1,        6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1c000210, 1'b0, 5'd5,  5'd4,  5'd5};
        vecs[16] = '{32'h5C001085, 32'h1c000200, 1'b0, 32'd9,        32'd9,        6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 5'd5,  5'd4,  5'd5};
        vecs[17] = '{32'h64001085, 32'h1c000200, 1'b0, 32'd1,        32'hffffffff, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1c000210, 1'b0, 5'd5,  5'd4,  5'd5};
        vecs[18] = '{32'h29800085, 32'h1c000300, 1'b0, 32'd0,        32'd0,        6'h25, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 5'd5,  5'd4,  5'd5};
        vecs[19] = '{32'h00100C40, 32'h1c000304, 1'b0, 32'd1,        32'd2,        6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 5'd0,  5'd2,  5'd3};
        vecs[20] = '{32'h00100041, 32'h1c000308, 1'b0, 32'd3,        32'd4,        6'h20, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 5'd1,  5'd2,  5'd0};
        vecs[21] = '{32'h14000041, 32'h1c00030c, 1'b0, 32'd3,        32'd4,        6'h22, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 5'd1,  5'd2,  5'd0};

        idle_inputs();
        fs_to_ds_bus = '0;
        rf_rdata1    = 32'h0;
        rf_rdata2    = 32'h0;
        reset        = 1'b1;
        step();
        step();
        chk("reset ds_to_es_valid", {31'b0, ds_to_es_valid}, 32'd0);
        chk("reset ds_allowin", {31'b0, ds_allowin}, 32'd1);
        chk("reset br_taken", {31'b0, br_collect[32]}, 32'd0);
        chk("reset br_target", br_collect[31:0], 32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < NVEC; i++) begin
            idle_inputs();
            load(vecs[i].inst, vecs[i].pc, vecs[i].adef);
            rf_rdata1   = vecs[i].rd1;
            rf_rdata2   = vecs[i].rd2;
            es_dest_bus = vecs[i].es_d;
            ms_dest_bus = vecs[i].ms_d;
            ws_dest_bus = vecs[i].ws_d;
            es_allowin  = vecs[i].es_allow;
            ws_flush    = vecs[i].flush;
            #1;
            chk($sformatf("v%0d ds_to_es_valid", i), {31'b0, ds_to_es_valid},
                {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d ds_allowin", i), {31'b0, ds_allowin},
                {31'b0, vecs[i].e_allowin});
            chk($sformatf("v%0d br_taken", i), {31'b0, br_collect[32]},
                {31'b0, vecs[i].e_taken});
            chk($sformatf("v%0d rf_raddr1", i), {27'b0, rf_raddr1}, {27'b0, vecs[i].e_raddr1});
            chk($sformatf("v%0d rf_raddr2", i), {27'b0, rf_raddr2}, {27'b0, vecs[i].e_raddr2});
            if (vecs[i].e_taken) begin
                chk($sformatf("v%0d br_target", i), br_collect[31:0], vecs[i].e_target);
            end
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d adef", i), {31'b0, ds_to_es_bus[134]},
                    {31'b0, vecs[i].adef});
                chk($sformatf("v%0d gr_we", i), {31'b0, ds_to_es_bus[133]},
                    {31'b0, vecs[i].e_gr_we});
                chk($sformatf("v%0d dest", i), {27'b0, ds_to_es_bus[132:128]},
                    {27'b0, vecs[i].e_dest});
                chk($sformatf("v%0d rkd_value", i), ds_to_es_bus[127:96], vecs[i].rd2);
                chk($sformatf("v%0d rj_value", i), ds_to_es_bus[95:64], vecs[i].rd1);
                chk($sformatf("v%0d inst", i), ds_to_es_bus[63:32], vecs[i].inst);
                chk($sformatf("v%0d pc", i), ds_to_es_bus[31:0], vecs[i].pc);
            end
            // Drain whatever is left in ID
            idle_inputs();
            step();
            step();
        end

        // RAW stall against EX for three cycles, then a single issue
        idle_inputs();
        load(32'h00100C41, 32'h1c000000, 1'b0);
        rf_rdata1   = 32'd5;
        rf_rdata2   = 32'd7;
        es_dest_bus = 6'h22;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall c%0d ds_to_es_valid", c), {31'b0, ds_to_es_valid}, 32'd0);
            chk($sformatf("stall c%0d ds_allowin", c), {31'b0, ds_allowin}, 32'd0);
            step();
        end
        es_dest_bus = 6'h00;
        #1;
        chk("stall release valid", {31'b0, ds_to_es_valid}, 32'd1);
        chk("stall release allowin", {31'b0, ds_allowin}, 32'd1);
        step();
        chk("stall issued once", {31'b0, ds_to_es_valid}, 32'd0);

        // Taken beq drops the sequential instruction fetched behind it
        idle_inputs();
        step();
        load(32'h58001085, 32'h1c000010, 1'b0);
        rf_rdata1      = 32'd9;
        rf_rdata2      = 32'd9;
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {1'b0, 32'h00100C41, 32'h1c000014};
        #1;
        chk("wrongpath br_taken", {31'b0, br_collect[32]}, 32'd1);
        chk("wrongpath br_target", br_collect[31:0], 32'h1c000020);
        step();
        fs_to_ds_valid = 1'b0;
        #1;
        chk("wrongpath dropped", {31'b0, ds_to_es_valid}, 32'd0);
        chk("wrongpath allowin", {31'b0, ds_allowin}, 32'd1);

        // EX back-pressure holds a ready beq without redirecting fetch
        idle_inputs();
        step();
        load(32'h58001085, 32'h1c000010, 1'b0);
        rf_rdata1  = 32'd9;
        rf_rdata2  = 32'd9;
        es_allowin = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("bp c%0d br_taken", c), {31'b0, br_collect[32]}, 32'd0);
            chk($sformatf("bp c%0d ds_allowin", c), {31'b0, ds_allowin}, 32'd0);
            chk($sformatf("bp c%0d ds_to_es_valid", c), {31'b0, ds_to_es_valid}, 32'd1);
            step();
        end
        es_allowin = 1'b1;
        #1;
        chk("bp release br_taken", {31'b0, br_collect[32]}, 32'd1);
        chk("bp release br_target", br_collect[31:0], 32'h1c000020);
        step();
        chk("bp issued once", {31'b0, ds_to_es_valid}, 32'd0);

        // Flush while stalled empties ID
        idle_inputs();
        step();
        load(32'h00100C41, 32'h1c000000, 1'b0);
        es_dest_bus = 6'h22;
        #1;
        chk("flush stalled allowin", {31'b0, ds_allowin}, 32'd0);
        ws_flush = 1'b1;
        #1;
        chk("flush cycle valid", {31'b0, ds_to_es_valid}, 32'd0);
        step();
        ws_flush    = 1'b0;
        es_dest_bus = 6'h00;
        #1;
        chk("flush after valid", {31'b0, ds_to_es_valid}, 32'd0);
        chk("flush after allowin", {31'b0, ds_allowin}, 32'd1);

        // Asynchronous reset while a beq is stalled
        idle_inputs();
        step();
        load(32'h58001085, 32'h1c000010, 1'b0);
        rf_rdata1   = 32'd9;
        rf_rdata2   = 32'd9;
        es_dest_bus = 6'h24;
        #1;
        chk("rst stalled allowin", {31'b0, ds_allowin}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("rst mid ds_to_es_valid", {31'b0, ds_to_es_valid}, 32'd0);
        chk("rst mid ds_allowin", {31'b0, ds_allowin}, 32'd1);
        chk("rst mid br_collect", br_collect[31:0], 32'd0);
        chk("rst mid br_taken", {31'b0, br_collect[32]}, 32'd0);
        step();
        reset       = 1'b0;
        es_dest_bus = 6'h00;
        #1;
        chk("rst after valid", {31'b0, ds_to_es_valid}, 32'd0);
        chk("rst after br_taken", {31'b0, br_collect[32]}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode pipeline stage directly downstream of the fetch stage.
- Latches the fetch bus, reads the register file and resolves branches in ID; returns br_collect and ds_allowin to fetch.
- Stalls on RAW hazards against EX/MEM/WB destinations (no forwarding).
- Passes operands, destination and fetch-exception flag to EX.

Parameters:
FS_BUS_W, 65, fetch bus {inst_adef, inst[31:0], pc[31:0]}
DS_BUS_W, 135, decode bus to EX
BR_BUS_W, 33, {br_taken, br_target[31:0]}

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
fs_to_ds_valid  in  1  fetch bus valid
fs_to_ds_bus  in  65  {inst_adef, inst, pc}
ds_allowin  out  1  ID can accept this cycle
br_collect  out  33  {br_taken, br_target}, combinational, same cycle
es_allowin  in  1  EX can accept
ds_to_es_valid  out  1  decode bus valid
ds_to_es_bus  out  135  {inst_adef[134], gr_we[133], dest[132:128], rkd_value[127:96], rj_value[95:64], inst[63:32], pc[31:0]}
rf_raddr1  out  5  = inst[9:5] (rj)
rf_rdata1  in  32  combinational read data
rf_raddr2  out  5  inst[4:0] if src2_is_rd, else inst[14:10]
rf_rdata2  in  32  combinational read data
es_dest_bus  in  6  {es_valid&gr_we, dest}
ms_dest_bus  in  6  {ms_valid&gr_we, dest}
ws_dest_bus  in  6  {ws_valid&gr_we, dest}
ws_flush  in  1  exception/ertn flush from WB

Behaviour:
- Reset (async): ds_valid=0, latched bus regs=0. Outputs: ds_to_es_valid=0, ds_allowin=1, br_collect=0. Reset mid-stall drops the held instruction.
- Decode on inst[31:26]:
  - jirl=0x13, b=0x14, bl=0x15.
  - beq=0x16, bne=0x17, blt=0x18, bge=0x19, bltu=0x1a, bgeu=0x1b.
  - store: inst[31:24]==8'h29. 3R: inst[31:22]==0 && inst[21:20]!=0.
- Sources and destination:
  - src2_is_rd = conditional branch | store.
  - rj_used = ~(b|bl|inst[31:25]==7'h0a|inst[31:25]==7'h0e).
  - src2_used = conditional branch | store | 3R.
  - dest = bl ? 1 : inst[4:0].
  - gr_we = ~(b|cond|store|inst_adef) && dest!=0.
- Hazard: used source reg !=0 matches any valid es/ms/ws dest. No forwarding; a WB match stalls too.
- ds_ready_go = ~hazard | inst_adef.
- ds_allowin = ~ds_valid | (ds_ready_go & es_allowin).
- ds_to_es_valid = ds_valid & ds_ready_go & ~ws_flush.
- Branch targets:
  - conditional and bl/b: pc + sext(offs<<2), where offs16 = inst[25:10] and offs26 = {inst[9:0], inst[25:10]}.
  - jirl: rj_value + sext(offs16<<2).
- Conditions: beq/bne equality; blt/bge signed; bltu/bgeu unsigned.
- br_taken = ds_valid & ds_ready_go & es_allowin & ~ws_flush & ~inst_adef & (b|bl|jirl|cond_true).
  - Gating with es_allowin keeps fetch from losing the target while EX is back-pressured.
- Update rule: on ds_allowin, ds_valid <= fs_to_ds_valid & ~br_taken & ~ws_flush, and the bus is latched. The sequential wrong-path instruction is dropped in the same cycle the branch leaves.
- ws_flush with ds_allowin=0: ds_valid <= 0.
- rj_value/rkd_value are sampled from rf_rdata combinationally when leaving ID; they are not stored.
- 32-bit adds wrap modulo 2^32.

Decomposition:
- Shared package: bus widths, opcode constants, and the ds_to_es_bus field offsets shared with the EX stage.
- One sub-module, id_branch_unit: condition compare and target adder, purely combinational.

Test Plan:
- add.w r1,r2,r3 (0x00100C41) pc 0x1c000000, rdata1=5, rdata2=7, es_allowin=1 -> next cycle ds_to_es_valid=1, dest=1, gr_we=1, rj_value=5, rkd_value=7, br_taken=0.
- beq r4,r5,+16 (0x58001085) pc 0x1c000010, both regs=9 -> br_collect={1,0x1c000020} that cycle; instruction at 0x1c000014 never appears with ds_to_es_valid=1.
- es_dest_bus={1,2} with add.w in ID for 3 cycles -> ds_allowin=0 and ds_to_es_valid=0 for 3 cycles, then issues once. Same hazard on a beq -> br_taken held 0.
- jirl r1,r6,8 (0x4C0020C1), rdata1=0x1c001000 -> target 0x1c001020, dest=1, gr_we=1.
- Ready beq taken with es_allowin=0 -> br_taken=0 and ID holds; es_allowin=1 -> br_taken=1 that cycle.
- Exception, flush and reset:
  - inst_adef=1, pc 0x1c000002, branch opcode -> passes with adef=1, gr_we=0, no branch.
  - ws_flush -> ds_valid=0 next cycle.
  - reset asserted mid-stall -> all outputs at reset values immediately.
